// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: arbitrates the CPU instruction-fetch and data ports onto a
// single SPI RAM master, one SPI transaction per request, with an optional
// one-entry fetch buffer that answers repeated fetches of the same word.
module spi_mem_bridge #(
  parameter int FETCH_BUF_EN = 1
) (
  input  logic        clk_core_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_data_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [15:0] d_addr_i,
  input  logic [7:0]  d_wdata_i,
  output logic [7:0]  d_rdata_o,
  output logic        d_ready_o,
  input  logic        fb_flush_i,
  output logic        busy_o,
  output logic        spi_start_o,
  output logic [15:0] spi_addr_o,
  output logic [7:0]  spi_wdata_o,
  output logic        spi_rnw_o,
  output logic [1:0]  spi_nbytes_o,
  input  logic [7:0]  spi_rdata1_i,
  input  logic [7:0]  spi_rdata2_i,
  input  logic        spi_done_i,
  input  logic        spi_busy_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_HIT
  } state_t;

  state_t      state;
  logic        lat_fetch;   // latched winner: 1 = fetch, 0 = data access
  logic        fb_valid;
  logic [15:0] fb_tag;
  logic [15:0] fb_word;
  logic [15:0] fb_tag_inc;
  logic        fb_hit;
  logic        fb_fill;
  logic        fb_store_hit;

  // A fetch covers tag and tag+1, so a store to either byte stales the word.
  assign fb_tag_inc   = fb_tag + 16'd1;
  assign fb_hit       = (FETCH_BUF_EN != 0) && fb_valid && if_req_i && !d_req_i &&
                        (fb_tag == if_addr_i);
  assign fb_fill      = (FETCH_BUF_EN != 0) && (state == S_WAIT) && spi_done_i && lat_fetch;
  assign fb_store_hit = (state == S_ISSUE) && !lat_fetch && !spi_rnw_o &&
                        ((spi_addr_o == fb_tag) || (spi_addr_o == fb_tag_inc));

  // Main sequencer: arbitration, SPI issue/wait, and registered responses.
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      lat_fetch    <= 1'b0;
      busy_o       <= 1'b0;
      spi_start_o  <= 1'b0;
      spi_addr_o   <= 16'h0000;
      spi_wdata_o  <= 8'h00;
      spi_rnw_o    <= 1'b1;
      spi_nbytes_o <= 2'b01;
      if_data_o    <= 16'h0000;
      if_ready_o   <= 1'b0;
      d_rdata_o    <= 8'h00;
      d_ready_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_req_i) begin
            state        <= S_ISSUE;
            busy_o       <= 1'b1;
            lat_fetch    <= 1'b0;
            spi_addr_o   <= d_addr_i;
            spi_wdata_o  <= d_wdata_i;
            spi_rnw_o    <= !d_we_i;
            spi_nbytes_o <= 2'b01;
            spi_start_o  <= !spi_busy_i;
          end else if (fb_hit) begin
            state      <= S_HIT;
            busy_o     <= 1'b1;
            if_data_o  <= fb_word;
            if_ready_o <= 1'b1;
          end else if (if_req_i) begin
            state        <= S_ISSUE;
            busy_o       <= 1'b1;
            lat_fetch    <= 1'b1;
            spi_addr_o   <= if_addr_i;
            spi_rnw_o    <= 1'b1;
            spi_nbytes_o <= 2'b10;
            spi_start_o  <= !spi_busy_i;
          end
        end
        S_ISSUE: begin
          // Start is raised only once the master reports idle; after the
          // single-cycle pulse the transaction is in flight.
          if (spi_start_o) begin
            state       <= S_WAIT;
            spi_start_o <= 1'b0;
          end else if (!spi_busy_i) begin
            spi_start_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (spi_done_i) begin
            state <= S_RESP;
            if (lat_fetch) begin
              if_data_o  <= {spi_rdata1_i, spi_rdata2_i};
              if_ready_o <= 1'b1;
            end else begin
              d_ready_o <= 1'b1;
              if (spi_rnw_o) begin
                d_rdata_o <= spi_rdata1_i;
              end
            end
          end
        end
        S_RESP, S_HIT: begin
          state      <= S_IDLE;
          busy_o     <= 1'b0;
          if_ready_o <= 1'b0;
          d_ready_o  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Fetch buffer valid bit: flush wins over a same-cycle fill.
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fb_valid <= 1'b0;
    end else if (fb_flush_i) begin
      fb_valid <= 1'b0;
    end else if (fb_fill) begin
      fb_valid <= 1'b1;
    end else if (fb_store_hit) begin
      fb_valid <= 1'b0;
    end
  end

  // Fetch buffer tag and word; qualified by fb_valid so no reset is needed.
  always_ff @(posedge clk_core_i) begin
    if (fb_fill) begin
      fb_tag  <= spi_addr_o;
      fb_word <= {spi_rdata1_i, spi_rdata2_i};
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge with a behavioural SPI RAM responder.
module tb_spi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, fb_flush, busy_force, mem_init;
  logic [15:0] if_addr, d_addr;
  logic [7:0]  d_wdata;

  // instance A (buffer enabled)
  logic [15:0] if_data_a, spi_addr_a;
  logic        if_ready_a, d_ready_a, busy_a, start_a, rnw_a, done_a, mbusy_a, spi_busy_a;
  logic [7:0]  d_rdata_a, spi_wdata_a, rd1_a, rd2_a;
  logic [1:0]  nbytes_a;
  // instance B (buffer disabled)
  logic        b_if_req;
  logic [15:0] b_if_addr, if_data_b, spi_addr_b;
  logic        if_ready_b, d_ready_b, busy_b, start_b, rnw_b, done_b, mbusy_b;
  logic [7:0]  d_rdata_b, spi_wdata_b, rd1_b, rd2_b;
  logic [1:0]  nbytes_b;

  logic [7:0]  mem [0:65535];
  int          cnt_a, cnt_b;
  logic [15:0] maddr_a, maddr_b;
  logic        mrnw_a;
  logic [7:0]  mwd_a;

  int start_cnt_a = 0, start_cnt_b = 0, ifr_cnt_a = 0, dr_cnt_a = 0, dn_cnt_a = 0;
  int overlap_err = 0, gap_err = 0, since_done = 100;
  logic [15:0] slog [$];
  logic [15:0] lst_addr;
  logic [7:0]  lst_wd;
  logic        lst_rnw;
  logic [1:0]  lst_nb;

  int n_checks = 0, n_errors = 0;

  assign spi_busy_a = mbusy_a | busy_force;

  always #5 clk = ~clk;

  spi_mem_bridge #(.FETCH_BUF_EN(1)) dut_a (
    .clk_core_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data_a), .if_ready_o(if_ready_a),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata_a), .d_ready_o(d_ready_a), .fb_flush_i(fb_flush), .busy_o(busy_a),
    .spi_start_o(start_a), .spi_addr_o(spi_addr_a), .spi_wdata_o(spi_wdata_a),
    .spi_rnw_o(rnw_a), .spi_nbytes_o(nbytes_a), .spi_rdata1_i(rd1_a), .spi_rdata2_i(rd2_a),
    .spi_done_i(done_a), .spi_busy_i(spi_busy_a)
  );

  spi_mem_bridge #(.FETCH_BUF_EN(0)) dut_b (
    .clk_core_i(clk), .rst_n_i(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_data_o(if_data_b), .if_ready_o(if_ready_b),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(16'h0000), .d_wdata_i(8'h00),
    .d_rdata_o(d_rdata_b), .d_ready_o(d_ready_b), .fb_flush_i(1'b0), .busy_o(busy_b),
    .spi_start_o(start_b), .spi_addr_o(spi_addr_b), .spi_wdata_o(spi_wdata_b),
    .spi_rnw_o(rnw_b), .spi_nbytes_o(nbytes_b), .spi_rdata1_i(rd1_b), .spi_rdata2_i(rd2_b),
    .spi_done_i(done_b), .spi_busy_i(mbusy_b)
  );

  // SPI RAM responder for A: done three cycles after start is seen
  always @(posedge clk) begin
    done_a <= 1'b0;
    if (mem_init) begin
      mem[16'h0100] <= 8'hAB; mem[16'h0101] <= 8'hCD;
      mem[16'h0102] <= 8'h00; mem[16'h0200] <= 8'h12;
      mem[16'h0201] <= 8'h34; mem[16'h0300] <= 8'h77;
      mem[16'hFFFF] <= 8'hEE; mem[16'h0000] <= 8'h11;
    end
    if (start_a) begin
      mbusy_a <= 1'b1; cnt_a <= 3;
      maddr_a <= spi_addr_a; mrnw_a <= rnw_a; mwd_a <= spi_wdata_a;
    end else if (mbusy_a) begin
      if (cnt_a == 1) begin
        done_a  <= 1'b1;
        mbusy_a <= 1'b0;
        rd1_a   <= mem[maddr_a];
        rd2_a   <= mem[16'(maddr_a + 16'd1)];
        if (!mrnw_a) mem[maddr_a] <= mwd_a;
      end
      cnt_a <= cnt_a - 1;
    end else if (!rst_n) begin
      mbusy_a <= 1'b0;
    end
  end

  // SPI RAM responder for B (read-only)
  always @(posedge clk) begin
    done_b <= 1'b0;
    if (start_b) begin
      mbusy_b <= 1'b1; cnt_b <= 3; maddr_b <= spi_addr_b;
    end else if (mbusy_b) begin
      if (cnt_b == 1) begin
        done_b  <= 1'b1;
        mbusy_b <= 1'b0;
        rd1_b   <= mem[maddr_b];
        rd2_b   <= mem[16'(maddr_b + 16'd1)];
      end
      cnt_b <= cnt_b - 1;
    end else if (!rst_n) begin
      mbusy_b <= 1'b0;
    end
  end

  // Event monitors: start log, pulse counts, overlap and done-to-start gap
  always @(posedge clk) begin
    if (start_a) begin
      start_cnt_a <= start_cnt_a + 1;
      slog.push_back(spi_addr_a);
      lst_addr <= spi_addr_a; lst_rnw <= rnw_a; lst_nb <= nbytes_a; lst_wd <= spi_wdata_a;
      if (mbusy_a) overlap_err <= overlap_err + 1;
      if (since_done < 1) gap_err <= gap_err + 1;
    end
    if (start_b) start_cnt_b <= start_cnt_b + 1;
    if (if_ready_a) ifr_cnt_a <= ifr_cnt_a + 1;
    if (d_ready_a) dr_cnt_a <= dr_cnt_a + 1;
    if (done_a) begin
      dn_cnt_a   <= dn_cnt_a + 1;
      since_done <= 0;
    end else if (since_done < 100) begin
      since_done <= since_done + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_if(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_ready_a && cyc < 100);
    if (!if_ready_a) check_eq("if_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_d(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!d_ready_a && cyc < 100);
    if (!d_ready_a) check_eq("d_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch_a(input logic [15:0] a, output logic [15:0] data,
                         output int cyc, output int starts);
    int s0;
    @(negedge clk);
    s0 = start_cnt_a;
    if_req = 1'b1; if_addr = a;
    wait_if(cyc);
    data = if_data_a;
    if_req = 1'b0;
    @(negedge clk);
    check_eq("if_ready_single", if_ready_a, 1'b0);
    starts = start_cnt_a - s0;
  endtask

  task automatic data_a(input logic we, input logic [15:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output int cyc, output int starts);
    int s0;
    @(negedge clk);
    s0 = start_cnt_a;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    wait_d(cyc);
    rd = d_rdata_a;
    d_req = 1'b0;
    @(negedge clk);
    check_eq("d_ready_single", d_ready_a, 1'b0);
    starts = start_cnt_a - s0;
  endtask

  task automatic fetch_b(input logic [15:0] a, output logic [15:0] data);
    int cyc;
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = a;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_ready_b && cyc < 100);
    if (!if_ready_b) check_eq("b_if_ready_timeout", 32'd0, 32'd1);
    data = if_data_b;
    b_if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] data;
    logic [7:0]  rd;
    int          cyc, starts, s0, r0, d0, q0, n0;

    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; fb_flush = 1'b0; busy_force = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 8'h0;
    b_if_req = 1'b0; b_if_addr = 16'h0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check_eq("rst_ready", {if_ready_a, d_ready_a, busy_a, start_a}, 4'b0000);
    check_eq("rst_if_data", if_data_a, 16'h0000);
    check_eq("rst_d_rdata", d_rdata_a, 8'h00);
    check_eq("rst_spi_addr", spi_addr_a, 16'h0000);
    check_eq("rst_spi_wdata", spi_wdata_a, 8'h00);
    check_eq("rst_rnw_nbytes", {rnw_a, nbytes_a}, 3'b101);

    // first fetch: miss through SPI
    fetch_a(16'h0100, data, cyc, starts);
    check_eq("t1_data", data, 16'hABCD);
    check_eq("t1_latency", cyc, 6);
    check_eq("t1_starts", starts, 1);
    check_eq("t1_addr", lst_addr, 16'h0100);
    check_eq("t1_rnw_nb", {lst_rnw, lst_nb}, 3'b110);

    // repeat fetch: buffer hit
    fetch_a(16'h0100, data, cyc, starts);
    check_eq("t2_hit_data", data, 16'hABCD);
    check_eq("t2_hit_latency", cyc, 1);
    check_eq("t2_hit_starts", starts, 0);

    // buffer disabled: every fetch goes to SPI
    fetch_b(16'h0100, data);
    fetch_b(16'h0100, data);
    check_eq("t2_nobuf_data", data, 16'hABCD);
    check_eq("t2_nobuf_starts", start_cnt_b, 2);

    // store into buffered word invalidates it
    data_a(1'b1, 16'h0101, 8'h55, rd, cyc, starts);
    check_eq("t4_store_starts", starts, 1);
    check_eq("t4_store_rnw_nb", {lst_rnw, lst_nb}, 3'b001);
    check_eq("t4_store_wdata", lst_wd, 8'h55);
    check_eq("t4_store_addr", lst_addr, 16'h0101);
    fetch_a(16'h0100, data, cyc, starts);
    check_eq("t4_refetch_starts", starts, 1);
    check_eq("t4_refetch_data", data, 16'hAB55);
    data_a(1'b1, 16'h0102, 8'h66, rd, cyc, starts);
    fetch_a(16'h0100, data, cyc, starts);
    check_eq("t4_nonoverlap_starts", starts, 0);
    check_eq("t4_nonoverlap_data", data, 16'hAB55);

    // load
    data_a(1'b0, 16'h0300, 8'h00, rd, cyc, starts);
    check_eq("ld_rdata", rd, 8'h77);
    check_eq("ld_latency", cyc, 6);
    check_eq("ld_rnw_nb", {lst_rnw, lst_nb}, 3'b101);

    // fetch at top of address space
    fetch_a(16'hFFFF, data, cyc, starts);
    check_eq("t5_data", data, 16'hEE11);
    check_eq("t5_addr", lst_addr, 16'hFFFF);
    check_eq("t5_nb", lst_nb, 2'b10);
    fetch_a(16'hFFFF, data, cyc, starts);
    check_eq("t5_hit_starts", starts, 0);
    data_a(1'b1, 16'h0000, 8'h22, rd, cyc, starts);
    fetch_a(16'hFFFF, data, cyc, starts);
    check_eq("t5_wrap_inval_starts", starts, 1);
    check_eq("t5_wrap_inval_data", data, 16'hEE22);

    // start held off while the master is busy
    busy_force = 1'b1;
    @(negedge clk);
    s0 = start_cnt_a;
    if_req = 1'b1; if_addr = 16'h0200;
    repeat (4) @(negedge clk);
    check_eq("busy_hold_nostart", start_cnt_a - s0, 0);
    check_eq("busy_hold_busy_o", busy_a, 1'b1);
    busy_force = 1'b0;
    wait_if(cyc);
    check_eq("busy_hold_data", if_data_a, 16'h1234);
    if_req = 1'b0;
    @(negedge clk);
    check_eq("busy_hold_starts", start_cnt_a - s0, 1);

    // simultaneous requests: data first, then fetch
    @(negedge clk);
    s0 = start_cnt_a; q0 = slog.size(); r0 = ifr_cnt_a; d0 = dr_cnt_a;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    if_req = 1'b1; if_addr = 16'h0100;
    wait_d(cyc);
    rd = d_rdata_a;
    d_req = 1'b0;
    wait_if(cyc);
    data = if_data_a;
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t3_ld_data", rd, 8'h77);
    check_eq("t3_if_data", data, 16'hAB55);
    check_eq("t3_starts", start_cnt_a - s0, 2);
    check_eq("t3_first_addr", slog[q0], 16'h0300);
    check_eq("t3_second_addr", slog[q0 + 1], 16'h0100);
    check_eq("t3_if_pulses", ifr_cnt_a - r0, 1);
    check_eq("t3_d_pulses", dr_cnt_a - d0, 1);

    // flush coincident with fill
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0200;
    cyc = 0;
    while (!done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_done_seen", done_a, 1'b1);
    fb_flush = 1'b1;
    @(negedge clk);
    fb_flush = 1'b0;
    check_eq("t6_flush_ready", if_ready_a, 1'b1);
    check_eq("t6_flush_data", if_data_a, 16'h1234);
    if_req = 1'b0;
    @(negedge clk);
    fetch_a(16'h0200, data, cyc, starts);
    check_eq("t6_flush_miss", starts, 1);

    // reset during WAIT; late done ignored
    @(negedge clk);
    s0 = start_cnt_a; r0 = ifr_cnt_a; n0 = dn_cnt_a;
    if_req = 1'b1; if_addr = 16'h0100;
    cyc = 0;
    while (start_cnt_a == s0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_rst_in_wait", busy_a, 1'b1);
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    check_eq("t6_rst_async_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("t6_late_done_seen", dn_cnt_a - n0, 1);
    check_eq("t6_no_ready", ifr_cnt_a - r0, 0);
    check_eq("t6_rst_outputs", {busy_a, start_a, rnw_a, nbytes_a}, 5'b00101);
    check_eq("t6_rst_addr", spi_addr_a, 16'h0000);
    check_eq("t6_rst_if_data", if_data_a, 16'h0000);
    fetch_a(16'h0200, data, cyc, starts);
    check_eq("t6_post_rst_miss", starts, 1);
    check_eq("t6_post_rst_data", data, 16'h1234);

    check_eq("no_overlapping_start", overlap_err, 0);
    check_eq("done_to_start_gap", gap_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
